rf_multiport: RTL and testbench

//  Parametrised multi-port RV32I register file with a pending-write scoreboard.

---
 rtl/rf_multiport.sv | 185 ++++++++++++++++++
 tb/tb_rf_multiport.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_multiport.sv
// Multi-port RV32I register file with a pending-write scoreboard.
// Read ports respond one cycle after the request; valid reports that no write to the register is still outstanding.
package core;
    localparam int RF_AW = 5;
    localparam int RF_DW = 32;

    typedef struct packed {
        logic [RF_AW-1:0] reg_addr;
        logic             en;
    } rf_read_req_t;

    typedef struct packed {
        logic [RF_DW-1:0] value;
        logic             valid;
        logic             done;
    } rf_read_rsp_t;

    typedef struct packed {
        logic [RF_AW-1:0] reg_addr;
        logic [RF_DW-1:0] value;
        logic             en;
    } rf_write_req_t;

    typedef struct packed {
        logic valid;
        logic done;
    } rf_write_rsp_t;

    localparam rf_read_rsp_t  rf_read_rsp_rst  = '0;
    localparam rf_write_rsp_t rf_write_rsp_rst = '0;
endpackage

// One read lane: decodes the request against storage, scoreboard and same-cycle writes, then registers the response.
module rf_read_port
    import core::*;
#(
    parameter int REG_COUNT = 32,
    parameter int REG_WIDTH = 32,
    parameter int BYPASS    = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  rf_read_req_t                        req,
    input  logic [REG_COUNT-1:0][REG_WIDTH-1:0] mem,
    input  logic [REG_COUNT-1:0]                busy,
    input  logic [REG_COUNT-1:0]                wr_hit,
    input  logic [REG_COUNT-1:0][REG_WIDTH-1:0] wr_val,
    output rf_read_rsp_t                        rsp
);
    rf_read_rsp_t nxt;
    logic         in_range;

    assign in_range = 32'(req.reg_addr) < REG_COUNT;

    always_comb begin
        nxt = rf_read_rsp_rst;
        if (req.en) begin
            nxt.done = 1'b1;
            if (req.reg_addr == '0) begin
                nxt.valid = 1'b1;
            end else if (in_range) begin
                for (int a = 0; a < REG_COUNT; a++) begin
                    if (req.reg_addr == RF_AW'(a)) begin
                        // A write landing this edge is the newest value, so it is current by definition.
                        if (BYPASS != 0 && wr_hit[a]) begin
                            nxt.value = RF_DW'(wr_val[a]);
                            nxt.valid = 1'b1;
                        end else begin
                            nxt.value = RF_DW'(mem[a]);
                            nxt.valid = ~busy[a];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rsp <= rf_read_rsp_rst;
        else     rsp <= nxt;
    end
endmodule

// Top: storage, write arbitration, reservation scoreboard and an array of read lanes.
module rf_multiport
    import core::*;
#(
    parameter int  NUM_RD    = 2,
    parameter int  NUM_WR    = 1,
    parameter int  NUM_RSV   = 1,
    parameter int  REG_COUNT = 32,
    parameter int  REG_WIDTH = 32,
    parameter int  BYPASS    = 1,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  rf_read_req_t  [NUM_RD-1:0]        rd_req_i,
    output rf_read_rsp_t  [NUM_RD-1:0]        rd_rsp_o,
    input  rf_write_req_t [NUM_WR-1:0]        wr_req_i,
    output rf_write_rsp_t [NUM_WR-1:0]        wr_rsp_o,
    input  logic          [NUM_RSV-1:0][AW-1:0] rsv_addr_i,
    input  logic          [NUM_RSV-1:0]       rsv_en_i,
    output logic          [REG_COUNT-1:0]     busy_o
);
    logic [REG_COUNT-1:0][REG_WIDTH-1:0] mem;
    logic [REG_COUNT-1:0][REG_WIDTH-1:0] wr_val;
    logic [REG_COUNT-1:0]                busy;
    logic [REG_COUNT-1:0]                wr_hit;
    logic [REG_COUNT-1:0]                rsv_hit;
    logic [NUM_WR-1:0]                   wr_commit;

    // Ascending port order lets the highest-index writer overwrite wr_val.
    always_comb begin
        wr_hit = '0;
        wr_val = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            for (int a = 1; a < REG_COUNT; a++) begin
                if (wr_req_i[w].en && wr_req_i[w].reg_addr == RF_AW'(a)) begin
                    wr_hit[a] = 1'b1;
                    wr_val[a] = wr_req_i[w].value[REG_WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        wr_commit = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_commit[w] = wr_req_i[w].en && wr_req_i[w].reg_addr != '0
                        && 32'(wr_req_i[w].reg_addr) < REG_COUNT;
            for (int v = w + 1; v < NUM_WR; v++) begin
                if (wr_req_i[v].en && wr_req_i[v].reg_addr == wr_req_i[w].reg_addr)
                    wr_commit[w] = 1'b0;
            end
        end
    end

    always_comb begin
        rsv_hit = '0;
        for (int r = 0; r < NUM_RSV; r++) begin
            for (int a = 0; a < REG_COUNT; a++) begin
                if (rsv_en_i[r] && rsv_addr_i[r] == AW'(a)) rsv_hit[a] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem      <= '0;
            busy     <= '0;
            wr_rsp_o <= {NUM_WR{rf_write_rsp_rst}};
        end else begin
            mem[0] <= '0;
            for (int a = 1; a < REG_COUNT; a++) begin
                if (wr_hit[a]) mem[a] <= wr_val[a];
            end
            // Reservation beats a same-cycle write: it names a newer producer.
            busy <= ((busy & ~wr_hit) | rsv_hit) & ~REG_COUNT'(1);
            for (int w = 0; w < NUM_WR; w++) begin
                wr_rsp_o[w].done  <= wr_req_i[w].en;
                wr_rsp_o[w].valid <= wr_commit[w];
            end
        end
    end

    assign busy_o = busy;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        rf_read_port #(
            .REG_COUNT (REG_COUNT),
            .REG_WIDTH (REG_WIDTH),
            .BYPASS    (BYPASS)
        ) u_rd (
            .clk    (clk),
            .rst    (rst),
            .req    (rd_req_i[p]),
            .mem    (mem),
            .busy   (busy),
            .wr_hit (wr_hit),
            .wr_val (wr_val),
            .rsp    (rd_rsp_o[p])
        );
    end
endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboarded bench: bypassing and non-bypassing register files share one stimulus stream and one reference model.
module tb_rf_multiport;
    import core::*;

    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int NRSV = 1;
    localparam int RC   = 24;
    localparam int AW   = $clog2(RC);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_read_req_t  [NRD-1:0]           rd_req;
    rf_write_req_t [NWR-1:0]           wr_req;
    logic          [NRSV-1:0][AW-1:0]  rsv_addr;
    logic          [NRSV-1:0]          rsv_en;
    rf_read_rsp_t  [NRD-1:0]           rd_rsp_b, rd_rsp_n;
    rf_write_rsp_t [NWR-1:0]           wr_rsp_b, wr_rsp_n;
    logic          [RC-1:0]            busy_b, busy_n;

    rf_multiport #(.NUM_RD(NRD), .NUM_WR(NWR), .NUM_RSV(NRSV), .REG_COUNT(RC), .REG_WIDTH(32), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .rd_req_i(rd_req), .rd_rsp_o(rd_rsp_b), .wr_req_i(wr_req), .wr_rsp_o(wr_rsp_b),
        .rsv_addr_i(rsv_addr), .rsv_en_i(rsv_en), .busy_o(busy_b));

    rf_multiport #(.NUM_RD(NRD), .NUM_WR(NWR), .NUM_RSV(NRSV), .REG_COUNT(RC), .REG_WIDTH(32), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .rd_req_i(rd_req), .rd_rsp_o(rd_rsp_n), .wr_req_i(wr_req), .wr_rsp_o(wr_rsp_n),
        .rsv_addr_i(rsv_addr), .rsv_en_i(rsv_en), .busy_o(busy_n));

    typedef struct packed {
        rf_read_rsp_t  [NRD-1:0] rd_b;
        rf_read_rsp_t  [NRD-1:0] rd_n;
        rf_write_rsp_t [NWR-1:0] wr;
        logic          [RC-1:0]  busy;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_mem[RC];
    bit          m_busy[RC];
    int          checks = 0;
    int          passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: applies the architectural rules to the inputs presented before the coming edge.
    task automatic model_step();
        exp_t        e;
        bit          hit;
        bit          rsv;
        logic [31:0] v;
        int          a;
        e = '0;
        if (rst) begin
            for (int i = 0; i < RC; i++) begin
                m_mem[i]  = 0;
                m_busy[i] = 0;
            end
        end else begin
            for (int p = 0; p < NRD; p++) begin
                if (rd_req[p].en) begin
                    a = int'(rd_req[p].reg_addr);
                    e.rd_b[p].done = 1'b1;
                    e.rd_n[p].done = 1'b1;
                    if (a == 0) begin
                        e.rd_b[p].valid = 1'b1;
                        e.rd_n[p].valid = 1'b1;
                    end else if (a < RC) begin
                        e.rd_n[p].value = m_mem[a];
                        e.rd_n[p].valid = !m_busy[a];
                        hit = 0;
                        v   = 0;
                        for (int w = 0; w < NWR; w++)
                            if (wr_req[w].en && int'(wr_req[w].reg_addr) == a) begin
                                hit = 1;
                                v   = wr_req[w].value;
                            end
                        e.rd_b[p].value = hit ? v : m_mem[a];
                        e.rd_b[p].valid = hit ? 1'b1 : !m_busy[a];
                    end
                end
            end
            for (int w = 0; w < NWR; w++) begin
                if (wr_req[w].en) begin
                    a = int'(wr_req[w].reg_addr);
                    e.wr[w].done  = 1'b1;
                    e.wr[w].valid = (a != 0) && (a < RC);
                    for (int u = w + 1; u < NWR; u++)
                        if (wr_req[u].en && int'(wr_req[u].reg_addr) == a) e.wr[w].valid = 1'b0;
                end
            end
            for (int r = 1; r < RC; r++) begin
                hit = 0;
                rsv = 0;
                v   = 0;
                for (int w = 0; w < NWR; w++)
                    if (wr_req[w].en && int'(wr_req[w].reg_addr) == r) begin
                        hit = 1;
                        v   = wr_req[w].value;
                    end
                for (int s = 0; s < NRSV; s++)
                    if (rsv_en[s] && int'(rsv_addr[s]) == r) rsv = 1;
                if (hit) m_mem[r] = v;
                m_busy[r] = (m_busy[r] && !hit) || rsv;
            end
        end
        for (int i = 0; i < RC; i++) e.busy[i] = m_busy[i];
        exp_q.push_back(e);
    endtask

    // Monitor: every edge presents one set of responses; pop the matching expectation and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            for (int p = 0; p < NRD; p++) begin
                chk($sformatf("rd_b[%0d]", p), 64'(rd_rsp_b[p]), 64'(e.rd_b[p]));
                chk($sformatf("rd_n[%0d]", p), 64'(rd_rsp_n[p]), 64'(e.rd_n[p]));
            end
            for (int w = 0; w < NWR; w++) begin
                chk($sformatf("wr_b[%0d]", w), 64'(wr_rsp_b[w]), 64'(e.wr[w]));
                chk($sformatf("wr_n[%0d]", w), 64'(wr_rsp_n[w]), 64'(e.wr[w]));
            end
            chk("busy_b", 64'(busy_b), 64'(e.busy));
            chk("busy_n", 64'(busy_n), 64'(e.busy));
        end
    end

    task automatic idle();
        rd_req   = '0;
        wr_req   = '0;
        rsv_addr = '0;
        rsv_en   = '0;
        rst      = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic rd(input int p, input int a);
        rd_req[p].en       = 1'b1;
        rd_req[p].reg_addr = RF_AW'(a);
    endtask

    task automatic wr(input int w, input int a, input logic [31:0] v);
        wr_req[w].en       = 1'b1;
        wr_req[w].reg_addr = RF_AW'(a);
        wr_req[w].value    = v;
    endtask

    task automatic rs(input int a);
        rsv_en[0]   = 1'b1;
        rsv_addr[0] = AW'(a);
    endtask

    function automatic int rnd_addr();
        if ($urandom_range(0, 9) < 7) return int'($urandom_range(0, 11));
        return int'($urandom_range(0, 31));
    endfunction

    initial begin
        idle();
        rst = 1'b1;
        tick();
        idle(); rd(0, 5); rd(1, 5); tick();
        idle(); wr(0, 5, 32'hDEADBEEF); tick();
        idle(); rd(0, 5); tick();
        idle(); wr(0, 7, 32'h12345678); rd(0, 7); rd(1, 7); tick();
        idle(); rd(0, 7); tick();
        idle(); rs(9); tick();
        idle(); rd(0, 9); tick();
        idle(); wr(1, 9, 32'h55); rd(1, 9); tick();
        idle(); rd(0, 9); tick();
        idle(); rs(9); wr(0, 9, 32'h66); rd(0, 9); tick();
        idle(); rd(0, 9); rs(9); tick();
        idle(); wr(0, 3, 32'h11); wr(1, 3, 32'h22); tick();
        idle(); rd(0, 3); rd(1, 3); tick();
        idle(); wr(0, 0, 32'hFF); rd(1, 0); tick();
        idle(); rd(0, 0); tick();
        idle(); wr(1, 30, 32'hABCD); rd(0, 30); rd(1, 23); rs(30); tick();
        idle(); rd(0, 30); tick();
        idle(); rst = 1'b1; rd(0, 5); wr(0, 4, 32'h4); rs(6); tick();
        idle(); rd(0, 5); rd(1, 4); tick();
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst = ($urandom_range(0, 63) == 0);
            for (int p = 0; p < NRD; p++)
                if ($urandom_range(0, 3) != 0) rd(p, rnd_addr());
            for (int w = 0; w < NWR; w++)
                if ($urandom_range(0, 2) == 0) wr(w, rnd_addr(), $urandom());
            if ($urandom_range(0, 3) == 0) rs(rnd_addr());
            tick();
        end
        idle();
        @(posedge clk);
        #2;
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
